// File: rtl/branch_predictor.sv
// Branch target buffer with saturating direction counters for fetch next-PC selection.
// Define BRANCH_PREDICTOR_RAS_EN to add a speculative return address stack.
module branch_predictor #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned ENTRIES   = 64,
    parameter int unsigned TAG_BITS  = 8,
    parameter int unsigned CTR_BITS  = 2,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_lu_valid,
    input  logic [XLEN-1:0] i_lu_pc,
    output logic            o_pred_hit,
    output logic            o_pred_taken,
    output logic [XLEN-1:0] o_pred_target,
    input  logic            i_upd_valid,
    input  logic [XLEN-1:0] i_upd_pc,
    input  logic            i_upd_taken,
    input  logic [XLEN-1:0] i_upd_target,
    input  logic [1:0]      i_upd_kind,
    input  logic            i_flush_all
);
    localparam int unsigned IdxW = $clog2(ENTRIES);
    localparam logic [1:0] KindCond = 2'b00;
    localparam logic [1:0] KindCall = 2'b10;
    localparam logic [1:0] KindRet  = 2'b11;
    localparam logic [CTR_BITS-1:0] CtrMax  = '1;
    localparam logic [CTR_BITS-1:0] CtrZero = '0;
    localparam logic [CTR_BITS-1:0] CtrWeak = CtrMax ^ (CtrMax >> 1);

    logic                r_valid  [ENTRIES];
    logic [TAG_BITS-1:0] r_tag    [ENTRIES];
    logic [XLEN-1:0]     r_target [ENTRIES];
    logic [1:0]          r_kind   [ENTRIES];
    logic [CTR_BITS-1:0] r_ctr    [ENTRIES];

    logic [IdxW-1:0]     w_lu_idx;
    logic [TAG_BITS-1:0] w_lu_tag;
    logic [XLEN-1:0]     w_lu_seq;
    logic                w_lu_hit;
    logic [IdxW-1:0]     w_upd_idx;
    logic [TAG_BITS-1:0] w_upd_tag;
    logic                w_upd_hit;
    logic                w_unused_pc;

    assign w_lu_idx    = i_lu_pc[IdxW+1:2];
    assign w_lu_tag    = i_lu_pc[IdxW+2+TAG_BITS-1:IdxW+2];
    assign w_lu_seq    = i_lu_pc + XLEN'(4);
    assign w_upd_idx   = i_upd_pc[IdxW+1:2];
    assign w_upd_tag   = i_upd_pc[IdxW+2+TAG_BITS-1:IdxW+2];
    assign w_unused_pc = ^{i_lu_pc, i_upd_pc};

    // Gating with reset keeps outputs on the miss rule while reset is held.
    assign w_lu_hit  = i_rst & i_lu_valid & r_valid[w_lu_idx] & (r_tag[w_lu_idx] == w_lu_tag);
    assign w_upd_hit = r_valid[w_upd_idx] & (r_tag[w_upd_idx] == w_upd_tag);

`ifdef BRANCH_PREDICTOR_RAS_EN
    localparam int unsigned RasPtrW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned RasCntW = $clog2(RAS_DEPTH + 1);
    localparam logic [RasPtrW-1:0] RasLast = RasPtrW'(RAS_DEPTH - 1);
    localparam logic [RasCntW-1:0] RasFull = RasCntW'(RAS_DEPTH);

    logic [XLEN-1:0]    r_ras [RAS_DEPTH];
    logic [RasPtrW-1:0] r_ras_ptr;
    logic [RasCntW-1:0] r_ras_cnt;
    logic [RasPtrW-1:0] w_ras_next;
    logic [RasPtrW-1:0] w_ras_prev;
    logic               w_ras_push;
    logic               w_ras_pop;

    // r_ras_ptr is the next free slot; when full it is also the oldest entry.
    assign w_ras_next = (r_ras_ptr == RasLast) ? '0 : r_ras_ptr + RasPtrW'(1);
    assign w_ras_prev = (r_ras_ptr == '0) ? RasLast : r_ras_ptr - RasPtrW'(1);
    assign w_ras_push = w_lu_hit & (r_kind[w_lu_idx] == KindCall);
    assign w_ras_pop  = w_lu_hit & (r_kind[w_lu_idx] == KindRet) & (r_ras_cnt != '0);

    always_ff @(posedge i_clk) begin
        if (!i_rst || i_flush_all) begin
            r_ras_ptr <= '0;
            r_ras_cnt <= '0;
        end else if (w_ras_push) begin
            r_ras[r_ras_ptr] <= w_lu_seq;
            r_ras_ptr        <= w_ras_next;
            if (r_ras_cnt != RasFull) r_ras_cnt <= r_ras_cnt + RasCntW'(1);
        end else if (w_ras_pop) begin
            r_ras_ptr <= w_ras_prev;
            r_ras_cnt <= r_ras_cnt - RasCntW'(1);
        end
    end
`else
    logic w_unused_ras;
    assign w_unused_ras = (RAS_DEPTH == 0);
`endif

    always_comb begin
        o_pred_hit    = w_lu_hit;
        o_pred_taken  = 1'b0;
        o_pred_target = w_lu_seq;
        if (w_lu_hit) begin
            if (r_kind[w_lu_idx] == KindCond) begin
                o_pred_taken = r_ctr[w_lu_idx][CTR_BITS-1];
                if (o_pred_taken) o_pred_target = r_target[w_lu_idx];
            end else begin
                o_pred_taken  = 1'b1;
                o_pred_target = r_target[w_lu_idx];
`ifdef BRANCH_PREDICTOR_RAS_EN
                if (w_ras_pop) o_pred_target = r_ras[w_ras_prev];
`endif
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
                r_ctr[i]   <= CtrZero;
            end
        end else if (i_flush_all) begin
            for (int i = 0; i < ENTRIES; i++) r_valid[i] <= 1'b0;
        end else if (i_upd_valid) begin
            if (w_upd_hit) begin
                if (i_upd_kind == KindCond) begin
                    if (i_upd_taken) begin
                        if (r_ctr[w_upd_idx] != CtrMax)
                            r_ctr[w_upd_idx] <= r_ctr[w_upd_idx] + CTR_BITS'(1);
                        r_target[w_upd_idx] <= i_upd_target;
                        r_kind[w_upd_idx]   <= i_upd_kind;
                    end else if (r_ctr[w_upd_idx] != CtrZero) begin
                        r_ctr[w_upd_idx] <= r_ctr[w_upd_idx] - CTR_BITS'(1);
                    end
                end else begin
                    r_target[w_upd_idx] <= i_upd_target;
                    r_kind[w_upd_idx]   <= i_upd_kind;
                    r_ctr[w_upd_idx]    <= CtrMax;
                end
            end else if (i_upd_taken) begin
                r_valid[w_upd_idx]  <= 1'b1;
                r_tag[w_upd_idx]    <= w_upd_tag;
                r_target[w_upd_idx] <= i_upd_target;
                r_kind[w_upd_idx]   <= i_upd_kind;
                r_ctr[w_upd_idx]    <= (i_upd_kind == KindCond) ? CtrWeak : CtrMax;
            end
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Table-driven bench for branch_predictor with an expected-result queue per cycle.
// Define BRANCH_PREDICTOR_RAS_EN to also run the return-stack sequences.
module tb_branch_predictor;
    logic        clk = 1'b0;
    logic        rst, lu_valid, upd_valid, upd_taken, flush_all;
    logic [31:0] lu_pc, upd_pc, upd_target;
    logic [1:0]  upd_kind;
    logic        pred_hit, pred_taken;
    logic [31:0] pred_target;

    always #5 clk = ~clk;

    branch_predictor dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_lu_valid   (lu_valid),
        .i_lu_pc      (lu_pc),
        .o_pred_hit   (pred_hit),
        .o_pred_taken (pred_taken),
        .o_pred_target(pred_target),
        .i_upd_valid  (upd_valid),
        .i_upd_pc     (upd_pc),
        .i_upd_taken  (upd_taken),
        .i_upd_target (upd_target),
        .i_upd_kind   (upd_kind),
        .i_flush_all  (flush_all)
    );

    typedef struct {
        string       nm;
        logic        rst, fl, uv, ut;
        logic [31:0] upc, utgt;
        logic [1:0]  uk;
        logic        lv;
        logic [31:0] lpc;
        logic        eh, et;
        logic [31:0] etgt;
    } vec_t;

    typedef struct {
        string       nm;
        logic        hit, taken;
        logic [31:0] tgt;
    } exp_t;

    exp_t sb_q[$];
    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(string nm, logic r, logic fl, logic uv, logic [31:0] upc,
                                logic ut, logic [1:0] uk, logic [31:0] utgt, logic lv,
                                logic [31:0] lpc, logic eh, logic et, logic [31:0] etgt);
        vec_t v;
        v.nm = nm; v.rst = r; v.fl = fl; v.uv = uv; v.upc = upc; v.ut = ut; v.uk = uk;
        v.utgt = utgt; v.lv = lv; v.lpc = lpc; v.eh = eh; v.et = et; v.etgt = etgt;
        return v;
    endfunction

    function automatic vec_t lk(string nm, logic [31:0] lpc, logic eh, logic et,
                                logic [31:0] etgt);
        return mk(nm, 1, 0, 0, 0, 0, 0, 0, 1, lpc, eh, et, etgt);
    endfunction

    function automatic vec_t up(string nm, logic [31:0] upc, logic ut, logic [1:0] uk,
                                logic [31:0] utgt, logic [31:0] lpc, logic eh, logic et,
                                logic [31:0] etgt);
        return mk(nm, 1, 0, 1, upc, ut, uk, utgt, 1, lpc, eh, et, etgt);
    endfunction

    task automatic cmp(string nm, string fld, logic [31:0] act, logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s.%s: got 0x%08h, expected 0x%08h", nm, fld, act, req);
        end
    endtask

    task automatic apply(input vec_t v);
        exp_t e;
        @(negedge clk);
        rst = v.rst; flush_all = v.fl; upd_valid = v.uv; upd_pc = v.upc; upd_taken = v.ut;
        upd_kind = v.uk; upd_target = v.utgt; lu_valid = v.lv; lu_pc = v.lpc;
        sb_q.push_back('{nm: v.nm, hit: v.eh, taken: v.et, tgt: v.etgt});
        #2;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s.queue: got empty scoreboard, expected one entry", v.nm);
        end else begin
            e = sb_q.pop_front();
            cmp(e.nm, "hit", {31'd0, pred_hit}, {31'd0, e.hit});
            cmp(e.nm, "taken", {31'd0, pred_taken}, {31'd0, e.taken});
            cmp(e.nm, "target", pred_target, e.tgt);
        end
    endtask

    initial begin
        rst = 0; flush_all = 0; upd_valid = 0; upd_pc = 0; upd_taken = 0; upd_kind = 0;
        upd_target = 0; lu_valid = 0; lu_pc = 0;

        tbl.push_back(mk("in_reset", 0, 0, 0, 0, 0, 0, 0, 1, 32'h100, 0, 0, 32'h104));
        tbl.push_back(lk("post_reset", 32'h100, 0, 0, 32'h104));
        tbl.push_back(up("alloc_nobypass", 32'h100, 1, 2'b00, 32'h80, 32'h100, 0, 0, 32'h104));
        tbl.push_back(lk("weak_taken", 32'h100, 1, 1, 32'h80));
        tbl.push_back(up("nt_ctr2", 32'h100, 0, 2'b00, 32'h0, 32'h100, 1, 1, 32'h80));
        tbl.push_back(up("nt_ctr1", 32'h100, 0, 2'b00, 32'h0, 32'h100, 1, 0, 32'h104));
        tbl.push_back(lk("ctr0", 32'h100, 1, 0, 32'h104));
        tbl.push_back(up("sat_lo", 32'h100, 0, 2'b00, 32'h0, 32'h100, 1, 0, 32'h104));
        tbl.push_back(up("t_ctr0", 32'h100, 1, 2'b00, 32'h80, 32'h100, 1, 0, 32'h104));
        tbl.push_back(up("t_ctr1", 32'h100, 1, 2'b00, 32'h80, 32'h100, 1, 0, 32'h104));
        tbl.push_back(up("t_ctr2", 32'h100, 1, 2'b00, 32'h80, 32'h100, 1, 1, 32'h80));
        tbl.push_back(up("t_ctr3", 32'h100, 1, 2'b00, 32'h80, 32'h100, 1, 1, 32'h80));
        tbl.push_back(up("sat_hi", 32'h100, 0, 2'b00, 32'h0, 32'h100, 1, 1, 32'h80));
        tbl.push_back(up("nt_from2", 32'h100, 0, 2'b00, 32'h0, 32'h100, 1, 1, 32'h80));
        tbl.push_back(lk("ctr1_after", 32'h100, 1, 0, 32'h104));
        tbl.push_back(lk("alias_miss", 32'h200, 0, 0, 32'h204));
        tbl.push_back(up("alias_alloc", 32'h200, 1, 2'b01, 32'h900, 32'h100, 1, 0, 32'h104));
        tbl.push_back(lk("alias_evict", 32'h100, 0, 0, 32'h104));
        tbl.push_back(lk("jump_hit", 32'h200, 1, 1, 32'h900));
        tbl.push_back(up("nt_miss_upd", 32'h300, 0, 2'b00, 32'h777, 32'h200, 1, 1, 32'h900));
        tbl.push_back(lk("nt_no_alloc", 32'h300, 0, 0, 32'h304));
        tbl.push_back(lk("jump_kept", 32'h200, 1, 1, 32'h900));
        tbl.push_back(up("same_cycle", 32'h40, 1, 2'b00, 32'h1000, 32'h40, 0, 0, 32'h44));
        tbl.push_back(lk("next_cycle", 32'h40, 1, 1, 32'h1000));
        tbl.push_back(mk("lu_invalid", 1, 0, 0, 0, 0, 0, 0, 0, 32'h40, 0, 0, 32'h44));
        tbl.push_back(up("ret_alloc", 32'h504, 1, 2'b11, 32'h2000, 32'h40, 1, 1, 32'h1000));
        tbl.push_back(lk("ret_stored", 32'h504, 1, 1, 32'h2000));
        tbl.push_back(lk("pc_wrap", 32'hFFFF_FFFC, 0, 0, 32'h0));
        tbl.push_back(mk("flush_upd", 1, 1, 1, 32'h80, 1, 2'b01, 32'h3000, 1, 32'h40, 1, 1,
                         32'h1000));
        tbl.push_back(lk("flushed_40", 32'h40, 0, 0, 32'h44));
        tbl.push_back(lk("flush_wins", 32'h80, 0, 0, 32'h84));
        tbl.push_back(lk("flushed_504", 32'h504, 0, 0, 32'h508));
        tbl.push_back(up("realloc", 32'h600, 1, 2'b01, 32'h4000, 32'h300, 0, 0, 32'h304));
        tbl.push_back(lk("realloc_hit", 32'h600, 1, 1, 32'h4000));
        tbl.push_back(mk("rst_mid_upd", 0, 0, 1, 32'h604, 1, 2'b01, 32'h5000, 1, 32'h600, 0,
                         0, 32'h604));
        tbl.push_back(lk("rst_cleared", 32'h600, 0, 0, 32'h604));
        tbl.push_back(lk("rst_discard", 32'h604, 0, 0, 32'h608));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

`ifdef BRANCH_PREDICTOR_RAS_EN
        apply(mk("ras_reset", 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 32'h4));
        apply(up("tr_call", 32'h10, 1, 2'b10, 32'h400, 32'h0, 0, 0, 32'h4));
        apply(up("tr_ret", 32'h404, 1, 2'b11, 32'h999, 32'h0, 0, 0, 32'h4));
        for (int k = 2; k <= 6; k++)
            apply(up("tr_nest", 32'(k * 16), 1, 2'b10, 32'h400, 32'h0, 0, 0, 32'h4));
        apply(lk("call_lu", 32'h10, 1, 1, 32'h400));
        apply(lk("ret_lu", 32'h404, 1, 1, 32'h14));
        for (int k = 2; k <= 6; k++) apply(lk("nest_call", 32'(k * 16), 1, 1, 32'h400));
        for (int k = 6; k >= 3; k--) apply(lk("nest_ret", 32'h404, 1, 1, 32'(k * 16 + 4)));
        apply(lk("ret_empty", 32'h404, 1, 1, 32'h999));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
